life_engine: RTL and testbench
==============================

LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 SHALL have parameter ROWS, default 8: number of grid rows, minimum 3.
REQ-002 SHALL have parameter COLS, default 8: number of grid columns, minimum 3.
REQ-003 SHALL have parameter WRAP, default 1: 1 means toroidal edges; 0 means cells outside the grid count as dead.
REQ-004 SHALL have parameter GEN_W, default 16: width of the generation counter.
REQ-005 SHALL have parameter RATE_W, default 8: width of the period input.
REQ-006 SHALL have parameter AUTO_HALT, default 1: 1 means the engine stops automatically on a stable or extinct grid.
REQ-007 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-008 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-009 Port load, input, 1 bit: copies seed into the grid.
REQ-010 Port seed, input, ROWS*COLS bits: initial pattern; bit index r*COLS+c, with row 0 in the LSBs.
REQ-011 Port start, input, 1 bit: starts continuous evolution.
REQ-012 Port stop, input, 1 bit: halts evolution.
REQ-013 Port step, input, 1 bit: performs a single generation.
REQ-014 Port period, input, RATE_W bits: the engine computes one generation every period+1 cycles.
REQ-015 Port grid, output, ROWS*COLS bits: current pattern.
REQ-016 Port gen_count, output, GEN_W bits: number of generations computed since the last load or reset.
REQ-017 Port busy, output, 1 bit: high while in RUN or SINGLE.
REQ-018 Port gen_done, output, 1 bit: one-cycle pulse in the cycle after each grid update.
REQ-019 Port stable, output, 1 bit: the last generation left the grid unchanged.
REQ-020 Port extinct, output, 1 bit: grid is all zero.

Function
REQ-021 SHALL apply rule B3/S23 to every cell each generation:
- live cell with 2 or 3 live neighbours survives;
- dead cell with exactly 3 live neighbours is born;
- all other cells are dead.
REQ-022 SHALL count all 8 Moore neighbours; row/column indices wrap modulo ROWS/COLS when WRAP=1.
REQ-023 SHALL compute the next grid combinationally from the registered grid; the grid register updates only on a generation tick.
REQ-024 SHALL implement FSM states IDLE, RUN and SINGLE.
REQ-025 FSM transitions SHALL be:
- IDLE to RUN on start;
- IDLE to SINGLE on step;
- RUN to IDLE on stop;
- SINGLE to IDLE after its one generation.
REQ-026 On entry to RUN or SINGLE, SHALL latch period into an internal register and clear the tick counter.
REQ-027 In RUN/SINGLE, a tick occurs when the tick counter equals the latched period; the first grid update is period+1 cycles after the start/step edge.
REQ-028 On each tick:
- gen_count increments modulo 2^GEN_W;
- stable is set when next equals grid, else cleared;
- gen_done pulses in the following cycle.
REQ-029 extinct SHALL be combinational: high when grid equals 0, including in IDLE.
REQ-030 When AUTO_HALT=1 and a tick yields stable=1 or an all-zero grid, RUN SHALL return to IDLE in the same cycle the grid updates.
REQ-031 load SHALL be honoured in any state. On load:
- grid takes seed;
- gen_count, stable and the tick counter clear;
- FSM goes to IDLE.
REQ-032 Priority for simultaneous inputs SHALL be load > stop > step > start.
REQ-033 SHALL ignore step and start while busy.
REQ-034 Stop asserted in the same cycle as a tick SHALL still let that tick's grid update complete.
REQ-035 period=0 SHALL produce one generation per cycle.

Reset
REQ-036 With reset low at a clock edge:
- grid = 0, gen_count = 0;
- busy = 0, gen_done = 0, stable = 0;
- FSM in IDLE and tick counter = 0;
- extinct = 1 because the grid is zero.
REQ-037 Reset low mid-RUN SHALL abort evolution with no further grid update.

Verification
REQ-038 Blinker, 8x8, WRAP=1: load bits 26,27,28; step with period=0 -> grid has bits 19,27,35; gen_count=1; gen_done pulses once; busy low 2 cycles after step.
REQ-039 Corners: seed bits 0,7,56. With WRAP=1, one step -> bits 0,7,56,63 set; a second step -> stable=1. With WRAP=0, one step -> grid=0 and extinct=1.
REQ-040 Auto-halt: load block bits 0,1,8,9 and start with period=3 -> first update 4 cycles after start; stable=1; busy drops; gen_count=1.
REQ-041 Rate and stop: blinker, period=4, start -> updates every 5 cycles; stop asserted on the third tick cycle -> gen_count=3 and the grid is vertical.
REQ-042 Priority and reset: load, stop and start asserted together while in RUN -> grid=seed, IDLE, gen_count=0. Reset low mid-RUN -> all outputs at their REQ-036 values on the next edge.

Source files
------------

// File: rtl/life_engine.sv
// life_engine: Conway B3/S23 cellular automaton over a ROWS x COLS grid with
// run/single-step control, programmable generation rate and auto-halt.
module life_engine #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int WRAP      = 1,
    parameter int GEN_W     = 16,
    parameter int RATE_W    = 8,
    parameter int AUTO_HALT = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 load_i,
    input  logic [ROWS*COLS-1:0] seed_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 step_i,
    input  logic [RATE_W-1:0]    period_i,
    output logic [ROWS*COLS-1:0] grid_o,
    output logic [GEN_W-1:0]     gen_count_o,
    output logic                 busy_o,
    output logic                 gen_done_o,
    output logic                 stable_o,
    output logic                 extinct_o
);
    localparam int N = ROWS * COLS;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] SINGLE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [N-1:0]      grid_q, grid_d, next_grid;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic [RATE_W-1:0] period_q, period_d, tick_q, tick_d;
    logic              stable_q, stable_d, done_q, done_d;
    logic              busy, tick, halt;

    // Neighbour k: 0..2 row above, 3/4 same row, 5..7 row below.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [7:0] nb;
            logic [3:0] cnt;
            for (genvar k = 0; k < 8; k++) begin : g_nb
                localparam int DR = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
                localparam int DC = (k < 3) ? k - 1 : ((k == 3) ? -1 : ((k == 4) ? 1 : k - 6));
                localparam int RR = r + DR;
                localparam int CC = c + DC;
                localparam bit INSIDE = RR >= 0 && RR < ROWS && CC >= 0 && CC < COLS;
                localparam int RW = (RR + ROWS) % ROWS;
                localparam int CW = (CC + COLS) % COLS;
                if (WRAP != 0 || INSIDE) begin : g_on
                    assign nb[k] = grid_q[RW*COLS+CW];
                end else begin : g_off
                    assign nb[k] = 1'b0;
                end
            end
            assign cnt = 4'($countones(nb));
            assign next_grid[r*COLS+c] = (cnt == 4'd3) || (cnt == 4'd2 && grid_q[r*COLS+c]);
        end
    end

    always_comb begin
        busy     = state_q != IDLE;
        tick     = busy && tick_q == period_q;
        halt     = AUTO_HALT != 0 && (next_grid == grid_q || next_grid == '0);
        state_d  = state_q;
        period_d = period_q;
        if (load_i) begin
            state_d = IDLE;
        end else if (busy) begin
            if (stop_i || (tick && (state_q == SINGLE || halt))) state_d = IDLE;
        end else if (!stop_i && (step_i || start_i)) begin
            state_d  = step_i ? SINGLE : RUN;
            period_d = period_i;
        end
        tick_d   = (load_i || !busy || tick) ? '0 : tick_q + 1'b1;
        grid_d   = load_i ? seed_i : (tick ? next_grid : grid_q);
        gen_d    = load_i ? '0 : gen_q + GEN_W'(tick);
        stable_d = load_i ? 1'b0 : (tick ? next_grid == grid_q : stable_q);
        done_d   = tick && !load_i;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            grid_q   <= '0;
            gen_q    <= '0;
            period_q <= '0;
            tick_q   <= '0;
            stable_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            gen_q    <= gen_d;
            period_q <= period_d;
            tick_q   <= tick_d;
            stable_q <= stable_d;
            done_q   <= done_d;
        end
    end

    assign grid_o      = grid_q;
    assign gen_count_o = gen_q;
    assign busy_o      = busy;
    assign gen_done_o  = done_q;
    assign stable_o    = stable_q;
    assign extinct_o   = grid_q == '0;
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: scoreboard bench for life_engine, toroidal and bounded instances.
module tb_life_engine;
    localparam int R = 8;
    localparam int C = 8;
    localparam int N = R * C;

    typedef struct {
        logic [N-1:0] g;
        logic [15:0]  n;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_ni = 1'b0;
    logic         load_i = 1'b0, start_i = 1'b0, stop_i = 1'b0, step_i = 1'b0;
    logic [N-1:0] seed_i = '0;
    logic [7:0]   period_i = '0;
    logic [N-1:0] grid_o, grid0_o;
    logic [15:0]  gen_o, gen0_o;
    logic         busy_o, busy0_o, done_o, done0_o, stable_o, stable0_o, ext_o, ext0_o;

    int           n_cmp = 0;
    int           n_bad = 0;
    exp_t         sb[$];
    exp_t         mon_e;
    logic [N-1:0] cur;
    logic [15:0]  gen;

    logic [N-1:0] blinker, vertical, corners, corners4, block, glider;

    always #5 clk = ~clk;

    life_engine #(.ROWS(R), .COLS(C), .WRAP(1)) u_dut (
        .clk_i(clk), .reset_ni(reset_ni), .load_i(load_i), .seed_i(seed_i),
        .start_i(start_i), .stop_i(stop_i), .step_i(step_i), .period_i(period_i),
        .grid_o(grid_o), .gen_count_o(gen_o), .busy_o(busy_o), .gen_done_o(done_o),
        .stable_o(stable_o), .extinct_o(ext_o)
    );

    life_engine #(.ROWS(R), .COLS(C), .WRAP(0)) u_dut0 (
        .clk_i(clk), .reset_ni(reset_ni), .load_i(load_i), .seed_i(seed_i),
        .start_i(start_i), .stop_i(stop_i), .step_i(step_i), .period_i(period_i),
        .grid_o(grid0_o), .gen_count_o(gen0_o), .busy_o(busy0_o), .gen_done_o(done0_o),
        .stable_o(stable0_o), .extinct_o(ext0_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] life(input logic [N-1:0] g, input bit wrap);
        logic [N-1:0] o;
        int cnt, rr, cc;
        o = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
                            if (wrap) begin
                                rr = (rr + R) % R;
                                cc = (cc + C) % C;
                            end
                            if (rr >= 0 && rr < R && cc >= 0 && cc < C) cnt += int'(g[rr*C+cc]);
                        end
                    end
                end
                o[r*C+c] = (cnt == 3) || (cnt == 2 && g[r*C+c]);
            end
        end
        return o;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [N-1:0] s);
        seed_i = s;
        load_i = 1'b1;
        cyc(1);
        load_i = 1'b0;
        cur = s;
        gen = '0;
    endtask

    task automatic push_tick();
        cur = life(cur, 1'b1);
        gen = gen + 16'd1;
        sb.push_back('{cur, gen});
    endtask

    always @(negedge clk) begin
        if (reset_ni && done_o) begin
            if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
            else begin
                mon_e = sb.pop_front();
                check("sb_grid", grid_o, mon_e.g);
                check("sb_gen", 64'(gen_o), 64'(mon_e.n));
            end
        end
    end

    initial begin
        blinker  = '0; blinker[26] = 1; blinker[27] = 1; blinker[28] = 1;
        vertical = '0; vertical[19] = 1; vertical[27] = 1; vertical[35] = 1;
        corners  = '0; corners[0] = 1; corners[7] = 1; corners[56] = 1;
        corners4 = corners; corners4[63] = 1;
        block    = '0; block[0] = 1; block[1] = 1; block[8] = 1; block[9] = 1;
        glider   = '0; glider[1] = 1; glider[10] = 1; glider[16] = 1; glider[17] = 1; glider[18] = 1;

        cyc(2);
        check("rst_grid", grid_o, '0);
        check("rst_gen", 64'(gen_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_stable", 64'(stable_o), 64'd0);
        check("rst_extinct", 64'(ext_o), 64'd1);
        reset_ni = 1'b1;
        cyc(1);

        do_load(blinker);
        check("load_extinct", 64'(ext_o), 64'd0);
        period_i = 8'd0;
        step_i = 1'b1;
        push_tick();
        cyc(1);
        step_i = 1'b0;
        check("blk_busy_single", 64'(busy_o), 64'd1);
        check("blk_gen_pre", 64'(gen_o), 64'd0);
        cyc(1);
        check("blk_grid", grid_o, vertical);
        check("blk_gen", 64'(gen_o), 64'd1);
        check("blk_busy_low", 64'(busy_o), 64'd0);
        check("blk_done", 64'(done_o), 64'd1);
        cyc(1);
        check("blk_done_once", 64'(done_o), 64'd0);

        do_load(corners);
        step_i = 1'b1;
        push_tick();
        cyc(1);
        step_i = 1'b0;
        cyc(1);
        check("crn_grid", grid_o, corners4);
        check("crn_stable0", 64'(stable_o), 64'd0);
        check("crn0_grid", grid0_o, '0);
        check("crn0_extinct", 64'(ext0_o), 64'd1);
        cyc(1);
        step_i = 1'b1;
        push_tick();
        cyc(1);
        step_i = 1'b0;
        cyc(1);
        check("crn_stable1", 64'(stable_o), 64'd1);
        check("crn_grid2", grid_o, corners4);
        cyc(1);

        do_load(block);
        period_i = 8'd3;
        start_i = 1'b1;
        push_tick();
        cyc(1);
        start_i = 1'b0;
        cyc(3);
        check("ah_gen_pre", 64'(gen_o), 64'd0);
        check("ah_busy_pre", 64'(busy_o), 64'd1);
        cyc(1);
        check("ah_gen", 64'(gen_o), 64'd1);
        check("ah_stable", 64'(stable_o), 64'd1);
        check("ah_busy", 64'(busy_o), 64'd0);
        cyc(2);

        do_load(blinker);
        period_i = 8'd4;
        start_i = 1'b1;
        repeat (3) push_tick();
        cyc(1);
        start_i = 1'b0;
        cyc(4);
        check("rate_gen0", 64'(gen_o), 64'd0);
        cyc(1);
        check("rate_gen1", 64'(gen_o), 64'd1);
        check("rate_grid1", grid_o, vertical);
        step_i = 1'b1;
        cyc(1);
        step_i = 1'b0;
        check("rate_busy_step", 64'(busy_o), 64'd1);
        cyc(4);
        check("rate_gen2", 64'(gen_o), 64'd2);
        check("rate_grid2", grid_o, blinker);
        cyc(4);
        stop_i = 1'b1;
        cyc(1);
        stop_i = 1'b0;
        check("stop_gen", 64'(gen_o), 64'd3);
        check("stop_grid", grid_o, vertical);
        check("stop_busy", 64'(busy_o), 64'd0);
        cyc(5);
        check("stop_hold", 64'(gen_o), 64'd3);

        do_load(blinker);
        period_i = 8'd2;
        start_i = 1'b1;
        push_tick();
        cyc(1);
        start_i = 1'b0;
        cyc(4);
        seed_i = glider;
        load_i = 1'b1; stop_i = 1'b1; start_i = 1'b1;
        cyc(1);
        load_i = 1'b0; stop_i = 1'b0; start_i = 1'b0;
        cur = glider;
        gen = '0;
        check("pri_grid", grid_o, glider);
        check("pri_busy", 64'(busy_o), 64'd0);
        check("pri_gen", 64'(gen_o), 64'd0);
        cyc(2);
        check("pri_idle", 64'(busy_o), 64'd0);

        stop_i = 1'b1; step_i = 1'b1; start_i = 1'b1;
        cyc(1);
        stop_i = 1'b0; step_i = 1'b0; start_i = 1'b0;
        check("pri_stop_idle", 64'(busy_o), 64'd0);
        period_i = 8'd0;
        step_i = 1'b1; start_i = 1'b1;
        push_tick();
        cyc(1);
        step_i = 1'b0; start_i = 1'b0;
        check("pri_step_busy", 64'(busy_o), 64'd1);
        cyc(1);
        check("pri_step_single", 64'(busy_o), 64'd0);
        check("pri_step_gen", 64'(gen_o), 64'd1);

        do_load(blinker);
        period_i = 8'd1;
        start_i = 1'b1;
        push_tick();
        cyc(1);
        start_i = 1'b0;
        cyc(3);
        reset_ni = 1'b0;
        cyc(1);
        check("mrst_grid", grid_o, '0);
        check("mrst_gen", 64'(gen_o), 64'd0);
        check("mrst_busy", 64'(busy_o), 64'd0);
        check("mrst_done", 64'(done_o), 64'd0);
        check("mrst_stable", 64'(stable_o), 64'd0);
        check("mrst_extinct", 64'(ext_o), 64'd1);
        reset_ni = 1'b1;
        cyc(2);
        check("mrst_hold_grid", grid_o, '0);
        check("mrst_hold_busy", 64'(busy_o), 64'd0);

        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
